// File: rtl/reg_dump_pkg.sv
//------------------------------------------------------------------------------
// Module   : reg_dump_pkg
// Brief    : Shared widths and FSM encodings for the register-file dump reader.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package reg_dump_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 5;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD   = 2'd1;
    localparam logic [1:0] c_SEND   = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

endpackage : reg_dump_pkg

`default_nettype wire

// File: rtl/reg_dump.sv
//------------------------------------------------------------------------------
// Module   : reg_dump
// Brief    : Walks registers FIRST_REG..LAST_REG through one read port and
//            streams each value on a valid/ready channel, stalling the core.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int ADDR_W    = c_ADDR_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    output logic [ADDR_W-1:0] DumpAddr,
    input  logic [DATA_W-1:0] DumpData,
    output logic              Stall,
    output logic              Busy,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [ADDR_W-1:0] OutIndex,
    output logic [DATA_W-1:0] OutData,
    output logic              Done
);

    localparam logic [ADDR_W-1:0] c_FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(LAST_REG);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_index;
    logic [DATA_W-1:0] r_out_data;
    logic              w_fire;

    assign w_fire = r_out_valid & OutReady;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= c_IDLE;
            r_idx       <= c_FIRST_IDX;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // Abort in the same cycle cancels the request outright
                    if (Start && !Abort) begin
                        r_state <= c_LOAD;
                        r_idx   <= c_FIRST_IDX;
                    end
                end
                c_LOAD: begin
                    if (Abort) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_out_data  <= DumpData;
                        r_out_index <= r_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (Abort) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end else if (w_fire) begin
                        r_out_valid <= 1'b0;
                        // Decide at LAST_REG so the index never needs to wrap
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_FINISH;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= c_LOAD;
                        end
                    end
                end
                c_FINISH: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign Busy     = (r_state != c_IDLE);
    assign Stall    = Busy;
    assign Done     = (r_state == c_FINISH);
    assign DumpAddr = (r_state == c_IDLE) ? '0 : r_idx;
    assign OutValid = r_out_valid;
    assign OutIndex = r_out_index;
    assign OutData  = r_out_data;

endmodule : reg_dump

`default_nettype wire

// File: tb/tb_reg_dump.sv
//------------------------------------------------------------------------------
// Module   : tb_reg_dump
// Brief    : Directed scoreboard bench for reg_dump (full range and 8..15).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_dump;
    import reg_dump_pkg::*;

    localparam int DW = c_DATA_W;
    localparam int AW = c_ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] regs [32];

    // Instance A: full 0..31 dump
    logic          a_rst, a_start, a_abort, a_ready;
    logic [AW-1:0] a_addr, a_idx;
    logic [DW-1:0] a_rdata, a_data;
    logic          a_stall, a_busy, a_valid, a_done;

    // Instance B: partial 8..15 dump
    logic          b_rst, b_start, b_abort, b_ready;
    logic [AW-1:0] b_addr, b_idx;
    logic [DW-1:0] b_rdata, b_data;
    logic          b_stall, b_busy, b_valid, b_done;

    assign a_rdata = regs[a_addr];
    assign b_rdata = regs[b_addr];

    reg_dump #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(31)) u_dut_a (
        .Clock(clk), .Reset(a_rst), .Start(a_start), .Abort(a_abort),
        .DumpAddr(a_addr), .DumpData(a_rdata), .Stall(a_stall), .Busy(a_busy),
        .OutValid(a_valid), .OutReady(a_ready), .OutIndex(a_idx),
        .OutData(a_data), .Done(a_done)
    );

    reg_dump #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(8), .LAST_REG(15)) u_dut_b (
        .Clock(clk), .Reset(b_rst), .Start(b_start), .Abort(b_abort),
        .DumpAddr(b_addr), .DumpData(b_rdata), .Stall(b_stall), .Busy(b_busy),
        .OutValid(b_valid), .OutReady(b_ready), .OutIndex(b_idx),
        .OutData(b_data), .Done(b_done)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    logic [AW+DW-1:0] q_a [$];
    logic [AW+DW-1:0] q_b [$];
    int beats_a, beats_b, done_cnt_a, done_cnt_b, done_at_a, done_at_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes complete at the next rising edge; inputs are stable here.
    task automatic mon();
        logic [AW+DW-1:0] e;
        if (a_valid && a_ready) begin
            beats_a++;
            chk("a_beat_expected", 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                chk("a_beat", {a_idx, a_data}, e);
            end
        end
        if (b_valid && b_ready) begin
            beats_b++;
            chk("b_beat_expected", 64'(q_b.size() != 0), 64'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                chk("b_beat", {b_idx, b_data}, e);
            end
        end
        if (a_done) begin
            done_cnt_a++;
            if (done_at_a < 0) done_at_a = cyc_n;
        end
        if (b_done) begin
            done_cnt_b++;
            if (done_at_b < 0) done_at_b = cyc_n;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a_dump();
        for (int i = 0; i < 32; i++) q_a.push_back({AW'(i), regs[i]});
        beats_a = 0; done_cnt_a = 0; done_at_a = -1;
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
        cyc_n = 0;
    endtask

    task automatic start_b_dump();
        for (int i = 8; i <= 15; i++) q_b.push_back({AW'(i), regs[i]});
        beats_b = 0; done_cnt_b = 0; done_at_b = -1;
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        cyc_n = 0;
    endtask

    task automatic run_a_until_idx(input int k);
        int n = 0;
        while (!(a_valid && a_idx == AW'(k)) && n < 200) begin cyc(); n++; end
        chk("a_reach_idx", 64'(a_valid && a_idx == AW'(k)), 64'd1);
    endtask

    task automatic wait_a_done();
        int n = 0;
        while (done_cnt_a == 0 && n < 300) begin cyc(); n++; end
        chk("a_done_seen", 64'(done_cnt_a != 0), 64'd1);
        repeat (3) cyc();
        chk("a_done_once", 64'(done_cnt_a), 64'd1);
        chk("a_queue_empty", 64'(q_a.size()), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] h_idx;
        logic [DW-1:0] h_data;
        int n;

        for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
        regs[0]  = 32'h0;
        regs[5]  = 32'hDEAD_BEEF;
        regs[31] = 32'h0000_1234;

        a_rst = 1'b1; a_start = 1'b1; a_abort = 1'b0; a_ready = 1'b1;
        b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1;
        beats_a = 0; beats_b = 0; done_cnt_a = 0; done_cnt_b = 0;
        done_at_a = -1; done_at_b = -1;

        // Reset held with Start high
        repeat (3) begin
            cyc();
            chk("rst_busy", a_busy, 1'b0);
            chk("rst_stall", a_stall, 1'b0);
            chk("rst_valid", a_valid, 1'b0);
            chk("rst_done", a_done, 1'b0);
            chk("rst_addr", a_addr, 5'd0);
            chk("rst_out", {a_idx, a_data}, 37'd0);
        end
        a_rst = 1'b0; a_start = 1'b0; b_rst = 1'b0;
        repeat (3) cyc();
        chk("idle_after_rst", a_busy, 1'b0);

        // Full dump with OutReady tied high
        start_a_dump();
        chk("a_busy_after_start", a_busy, 1'b1);
        chk("a_stall_after_start", a_stall, 1'b1);
        wait_a_done();
        chk("a_beats_32", 64'(beats_a), 64'd32);
        chk("a_done_latency", 64'(done_at_a), 64'd65);
        chk("a_idle_after_done", a_busy, 1'b0);

        // Backpressure at beat 7 and a stray Start at beat 10
        start_a_dump();
        run_a_until_idx(7);
        a_ready = 1'b0;
        h_idx = a_idx; h_data = a_data;
        repeat (4) begin
            cyc();
            chk("bp_valid", a_valid, 1'b1);
            chk("bp_index", a_idx, 5'd7);
            chk("bp_data", a_data, h_data);
            chk("bp_stall", a_stall, 1'b1);
        end
        chk("bp_held_idx", h_idx, 5'd7);
        a_ready = 1'b1;
        run_a_until_idx(10);
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
        wait_a_done();
        chk("bp_beats_32", 64'(beats_a), 64'd32);

        // Abort in SEND at beat 12
        start_a_dump();
        run_a_until_idx(12);
        chk("ab_beats_before", 64'(beats_a), 64'd12);
        a_abort = 1'b1; a_ready = 1'b0;
        cyc();
        a_abort = 1'b0;
        chk("ab_valid", a_valid, 1'b0);
        chk("ab_busy", a_busy, 1'b0);
        chk("ab_stall", a_stall, 1'b0);
        q_a.delete();
        repeat (4) cyc();
        chk("ab_no_done", 64'(done_cnt_a), 64'd0);

        // Start and Abort together in IDLE
        a_start = 1'b1; a_abort = 1'b1;
        cyc();
        a_start = 1'b0; a_abort = 1'b0;
        chk("start_abort_idle", a_busy, 1'b0);
        cyc();
        chk("start_abort_idle2", a_busy, 1'b0);

        // Fresh dump restarts at FIRST_REG
        a_ready = 1'b1;
        start_a_dump();
        wait_a_done();
        chk("restart_beats_32", 64'(beats_a), 64'd32);

        // Partial range, reset mid-dump at beat 11
        start_b_dump();
        n = 0;
        while (!(b_valid && b_idx == 5'd11) && n < 200) begin cyc(); n++; end
        chk("b_reach_11", 64'(b_valid && b_idx == 5'd11), 64'd1);
        b_rst = 1'b1; b_ready = 1'b0;
        cyc();
        b_rst = 1'b0;
        chk("b_rst_valid", b_valid, 1'b0);
        chk("b_rst_busy", b_busy, 1'b0);
        chk("b_rst_out", {b_idx, b_data}, 37'd0);
        q_b.delete();
        repeat (3) cyc();
        chk("b_rst_no_done", 64'(done_cnt_b), 64'd0);

        b_ready = 1'b1;
        start_b_dump();
        n = 0;
        while (done_cnt_b == 0 && n < 100) begin cyc(); n++; end
        chk("b_done_seen", 64'(done_cnt_b != 0), 64'd1);
        repeat (3) cyc();
        chk("b_done_once", 64'(done_cnt_b), 64'd1);
        chk("b_beats_8", 64'(beats_b), 64'd8);
        chk("b_done_latency", 64'(done_at_b), 64'd17);
        chk("b_queue_empty", 64'(q_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_reg_dump

`default_nettype wire

// File: doc/reg_dump.md
Name: reg_dump

Overview:
- Sequential reader for the 32x32 register file: on request, walks registers FIRST_REG..LAST_REG through one read port and streams each value out on a valid/ready channel.
- Sits beside the datapath and drives the register file's second read address while active.
- Asserts Stall for the whole dump so the core holds RegWrite low, giving a consistent snapshot.
- Used by the debug/trace path and by testbench end-of-program checks.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width.
- FIRST_REG, 0, first index dumped.
- LAST_REG, 31, last index dumped; must satisfy FIRST_REG <= LAST_REG <= 2^ADDR_W-1.

Ports:
- Clock     in   1       single clock; all state updates on the rising edge.
- Reset     in   1       synchronous, active-high.
- Start     in   1       request a dump; sampled only in IDLE.
- Abort     in   1       synchronous cancel of a dump in progress.
- DumpAddr  out  ADDR_W  to the register file read address.
- DumpData  in   DATA_W  combinational read data returned for DumpAddr.
- Stall     out  1       high while Busy; the core must suppress RegWrite.
- Busy      out  1       high in any state other than IDLE.
- OutValid  out  1       output beat valid.
- OutReady  in   1       sink accepts the beat.
- OutIndex  out  ADDR_W  register index of the current beat.
- OutData   out  DATA_W  register value of the current beat.
- Done      out  1       one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: state IDLE, idx = FIRST_REG, DumpAddr = 0, OutValid = 0, OutIndex = 0, OutData = 0, Done = 0, Busy = 0, Stall = 0.
- Reset has priority over Abort and Start, including mid-dump. It returns the block to IDLE on the next edge, drops OutValid and emits no Done.
- States: IDLE, LOAD, SEND, FINISH.
- IDLE:
  - Start=1 -> LOAD, with idx <= FIRST_REG.
  - DumpAddr = idx is driven combinationally in every state; DumpAddr = 0 in IDLE.
- LOAD:
  - DumpAddr = idx.
  - On the edge: OutData <= DumpData, OutIndex <= idx, OutValid <= 1, then -> SEND.
- SEND:
  - OutValid, OutIndex and OutData are held stable until OutValid & OutReady.
  - On handshake with idx == LAST_REG: OutValid <= 0, -> FINISH.
  - On handshake otherwise: idx <= idx + 1, OutValid <= 0, -> LOAD.
- FINISH: Done = 1 for exactly this cycle, then -> IDLE.
- Latency and throughput:
  - Start sampled at edge t -> LOAD during cycle t+1 -> OutValid high from edge t+2.
  - With OutReady tied high, one beat per 2 cycles.
  - A full default dump takes 2*32 + 1 cycles from Start to Done.
- Start while Busy is ignored; no queuing.
- Start and Abort together in IDLE: Abort wins and Start is ignored.
- Abort in LOAD or SEND -> IDLE on the next edge. OutValid drops without a handshake, which is the only permitted withdrawal of a valid beat. No Done is emitted.
- Abort in FINISH: Done still pulses.
- Register 0 reads as 0 through the register file; the block does no special-casing.
- idx never wraps: the transition is decided at LAST_REG, so LAST_REG = 31 with ADDR_W = 5 is safe.
- Stall = Busy, combinational from state. The core may observe a write that was already in flight in the cycle Start was sampled; that write lands before LOAD.

Decomposition:
- Shared package (reg_dump_pkg): state encodings (IDLE=2'd0, LOAD=2'd1, SEND=2'd2, FINISH=2'd3) and the default widths DATA_W / ADDR_W, shared with the register file.
- Single module; no sub-module is warranted. The FSM, index counter and output holding register are all small.

Test Plan:
1. Reset held 3 cycles with Start=1 -> all outputs at reset values, Busy=0; after release the block stays in IDLE until Start is seen with Reset low.
2. Preload regs[5]=32'hDEADBEEF and regs[31]=32'h0000_1234, OutReady=1, pulse Start -> exactly 32 beats with OutIndex 0..31 in order. Beat 0 data is 0, beat 5 is DEADBEEF, beat 31 is 00001234. Done pulses once, 65 cycles after the Start edge.
3. Backpressure: OutReady low for 4 cycles during beat 7 -> OutValid, OutIndex=7 and OutData held constant. No skipped or duplicated index; Stall stays high throughout.
4. Start pulsed again at beat 10 -> ignored; the dump completes normally with a single Done.
5. Abort asserted while SEND at beat 12 -> OutValid=0, Busy=0, Stall=0 on the next edge, no Done; a fresh Start restarts at index FIRST_REG.
6. FIRST_REG=8, LAST_REG=15, plus Reset asserted at beat 11 -> the first run stops with no Done; a rerun emits indices 8..15 only, and Done follows the beat at index 15.
